// File: rtl/adder_pkg.sv
// Shared definitions for the serial arithmetic stages: FSM encoding,
// handshake naming and derived-width helpers.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam string HS_IN_VALID  = "in_valid";
  localparam string HS_IN_READY  = "in_ready";
  localparam string HS_OUT_VALID = "out_valid";
  localparam string HS_OUT_READY = "out_ready";

  // Counter width for a WIDTH-bit serial walk; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half adders, used as the reusable serial slice.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
  half_adder u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

  assign co = c0 | c1;
endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first bit-serial adder: one full-add slice reused WIDTH cycles with a
// registered carry, valid/ready handshake on both operand and result sides.
module bit_serial_adder
  import adder_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_co;
  logic [WIDTH:0]   sum_shift;

  full_adder_bit u_fa (
    .a (ra_q[0]),
    .b (rb_q[0]),
    .ci(carry_q),
    .s (fa_s),
    .co(fa_co)
  );

  // New bit enters at the MSB; the concatenation also covers WIDTH=1.
  assign sum_shift = {fa_s, sum_q};

  always_comb begin
    state_d   = state_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          ra_d    = a;
          rb_d    = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        carry_d = fa_co;
        ra_d    = ra_q >> 1;
        rb_d    = rb_q >> 1;
        sum_d   = sum_shift[WIDTH:1];
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

  // The carry flop doubles as cout once the last bit has been added.
  assign sum  = sum_q;
  assign cout = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized self-checking bench for bit_serial_adder (WIDTH=8 and WIDTH=1 instances).
module tb_bit_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, ci8, co8, bz8;
  logic [7:0] a8, b8, s8;
  logic       iv1, ir1, ov1, or1, ci1, co1, bz1;
  logic [0:0] a1, b1, s1;

  bit_serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(ci8),
    .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
  );

  bit_serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(ci1),
    .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain arithmetic, cout is bit 8 of the 9-bit sum.
  function automatic logic [8:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic c);
    return 9'(a) + 9'(b) + 9'(c);
  endfunction

  // Full transaction on the 8-bit DUT; lat counts edges from the accepting one inclusive.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     output logic [7:0] s, output logic co, output int lat);
    int w = 0;
    while (!ir8 && w < 50) begin tick(); w++; end
    chk("op8_ready", 64'(ir8), 64'(1));
    a8 = a; b8 = b; ci8 = c; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    lat = 1;
    while (!ov8 && lat < 100) begin tick(); lat++; end
    s = s8; co = co8;
    or8 = 1'b1;
    tick();
    or8 = 1'b0;
  endtask

  task automatic op1(input logic a, input logic b, input logic c,
                     output logic s, output logic co, output int lat);
    int w = 0;
    while (!ir1 && w < 50) begin tick(); w++; end
    a1 = a; b1 = b; ci1 = c; iv1 = 1'b1;
    tick();
    iv1 = 1'b0;
    lat = 1;
    while (!ov1 && lat < 100) begin tick(); lat++; end
    s = s1[0]; co = co1;
    or1 = 1'b1;
    tick();
    or1 = 1'b0;
  endtask

  logic [7:0] rs;
  logic       rc;
  int         lat;
  logic [8:0] e;

  initial begin
    rst_n = 1'b0;
    {iv8, or8, ci8, a8, b8} = '0;
    {iv1, or1, ci1, a1, b1} = '0;
    #12;
    chk("rst_in_ready", 64'(ir8), 64'(1));
    chk("rst_out_valid", 64'(ov8), 64'(0));
    chk("rst_busy", 64'(bz8), 64'(0));
    chk("rst_sum", 64'(s8), 64'(0));
    chk("rst_cout", 64'(co8), 64'(0));
    chk("rst_in_ready_w1", 64'(ir1), 64'(1));
    rst_n = 1'b1;
    tick();

    // Test 1: basic add and latency
    op8(8'h0F, 8'h01, 1'b0, rs, rc, lat);
    chk("t1_sum", 64'(rs), 64'(8'h10));
    chk("t1_cout", 64'(rc), 64'(0));
    chk("t1_latency", 64'(lat), 64'(9));

    // Test 2: overflow / wrap
    op8(8'hFF, 8'h01, 1'b0, rs, rc, lat);
    chk("t2a_sum", 64'(rs), 64'(8'h00));
    chk("t2a_cout", 64'(rc), 64'(1));
    op8(8'hFF, 8'hFF, 1'b1, rs, rc, lat);
    chk("t2b_sum", 64'(rs), 64'(8'hFF));
    chk("t2b_cout", 64'(rc), 64'(1));

    // Test 3: backpressure in DONE with in_valid pulses
    a8 = 8'h33; b8 = 8'h44; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    for (int i = 0; i < 20 && !ov8; i++) tick();
    chk("t3_valid_up", 64'(ov8), 64'(1));
    for (int i = 0; i < 5; i++) begin
      iv8 = i[0];
      a8 = 8'($urandom);
      tick();
      chk("t3_hold_valid", 64'(ov8), 64'(1));
      chk("t3_hold_sum", 64'(s8), 64'(8'h77));
      chk("t3_hold_cout", 64'(co8), 64'(0));
      chk("t3_hold_inrdy", 64'(ir8), 64'(0));
    end
    iv8 = 1'b1; or8 = 1'b1;
    tick();
    chk("t3_release_valid", 64'(ov8), 64'(0));
    chk("t3_release_idle", 64'(ir8), 64'(1));
    chk("t3_release_busy", 64'(bz8), 64'(0));
    iv8 = 1'b0; or8 = 1'b0;

    // Test 4: async reset in RUN discards the partial result
    a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 64'(ov8), 64'(0));
    chk("t4_rst_sum", 64'(s8), 64'(0));
    chk("t4_rst_cout", 64'(co8), 64'(0));
    chk("t4_rst_inrdy", 64'(ir8), 64'(1));
    chk("t4_rst_busy", 64'(bz8), 64'(0));
    #2 rst_n = 1'b1;
    tick();
    op8(8'h01, 8'h02, 1'b0, rs, rc, lat);
    chk("t4_sum", 64'(rs), 64'(8'h03));
    chk("t4_cout", 64'(rc), 64'(0));
    begin
      int extra = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (ov8) extra++;
      end
      chk("t4_single_result", 64'(extra), 64'(0));
    end

    // Test 5: back-to-back random stream, in_valid held, out_ready tied high
    begin
      logic [8:0] q[$];
      int acc = 0, last_acc = -1, cycle = 0;
      logic was_rdy, was_iv;
      a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
      iv8 = 1'b1; or8 = 1'b1;
      while ((acc < 1000 || q.size() != 0) && cycle < 20000) begin
        was_rdy = ir8;
        was_iv  = iv8;
        tick();
        cycle++;
        if (ov8) begin
          if (q.size() == 0) chk("t5_spurious", 64'(1), 64'(0));
          else begin
            e = q.pop_front();
            chk("t5_sum", 64'(s8), 64'(e[7:0]));
            chk("t5_cout", 64'(co8), 64'(e[8]));
          end
        end
        if (was_rdy && was_iv) begin
          q.push_back(ref8(a8, b8, ci8));
          if (last_acc >= 0) chk("t5_spacing", 64'(cycle - last_acc), 64'(10));
          last_acc = cycle;
          acc++;
          if (acc < 1000) begin
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
          end else iv8 = 1'b0;
        end
      end
      chk("t5_accepted", 64'(acc), 64'(1000));
      chk("t5_drained", 64'(q.size()), 64'(0));
      iv8 = 1'b0; or8 = 1'b0;
    end

    // Test 6: WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      logic [1:0] ex;
      v  = 3'(i);
      ex = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      op1(v[2], v[1], v[0], rs[0], rc, lat);
      chk("t6_sum", 64'(rs[0]), 64'(ex[0]));
      chk("t6_cout", 64'(rc), 64'(ex[1]));
      chk("t6_latency", 64'(lat), 64'(2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
